seg_capture: RTL and testbench

//   Inverse of the digit-to-segment encoder: observes a multiplexed, active-low 7-segment display bus.

---
 rtl/seg_capture.sv | 127 ++++++++++++
 tb/tb_seg_capture.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_capture.sv
// Observes a multiplexed active-low 7-segment bus and recovers one 4-bit code per digit.
// A pattern is committed to its slot once it has been sampled STABLE_CYCLES times in a row.
module seg_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int IDX_W         = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    digit_valid,
  output logic [IDX_W-1:0]        digit_idx,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      CNT_ARM  = CNT_W'(STABLE_CYCLES - 2);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [NUM_DIGITS-1:0] SEL_ONE  = NUM_DIGITS'(1);

  // Pin sample (stage 1) and the sample before it, used for the equality test.
  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_an;
  logic [6:0]            p_seg;
  logic [NUM_DIGITS-1:0] p_an;

  logic [CNT_W-1:0]      cnt;
  logic                  done;
  logic [NUM_DIGITS-1:0] seen;

  logic [NUM_DIGITS-1:0] sel;
  logic                  one_hot;
  logic                  same;
  logic                  commit;
  logic [IDX_W-1:0]      slot;
  logic [4:0]            decoded;
  logic [NUM_DIGITS-1:0] seen_next;
  logic                  frame_full;

  // Returns {err, code}; anything outside the digit set and the dash is an error.
  function automatic logic [4:0] decode_seg(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'b1000000: r = {1'b0, 4'h0};
      7'b1111001: r = {1'b0, 4'h1};
      7'b0100100: r = {1'b0, 4'h2};
      7'b0110000: r = {1'b0, 4'h3};
      7'b0011001: r = {1'b0, 4'h4};
      7'b0010010: r = {1'b0, 4'h5};
      7'b0000010: r = {1'b0, 4'h6};
      7'b1111000: r = {1'b0, 4'h7};
      7'b0000000: r = {1'b0, 4'h8};
      7'b0010000: r = {1'b0, 4'h9};
      7'b0111111: r = {1'b0, 4'hA};
      default:    r = {1'b1, 4'hF};
    endcase
    return r;
  endfunction

  // digit_valid is a bare one-cycle strobe: there is no ready, a consumer must catch the pulse.
  always_comb begin
    sel        = ~s_an;
    one_hot    = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
    same       = (s_seg == p_seg) && (s_an == p_an);
    // The commit lands on the edge where the count reaches its last value.
    commit     = one_hot && same && !done && (cnt == CNT_ARM);
    decoded    = decode_seg(s_seg);
    seen_next  = seen | sel;
    frame_full = &seen_next;
    slot       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel[i]) slot = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_seg       <= 7'h7F;
      s_an        <= '1;
      p_seg       <= 7'h7F;
      p_an        <= '1;
      cnt         <= '0;
      done        <= 1'b0;
      seen        <= '0;
      digits      <= '1;
      digit_err   <= '1;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      frame_done  <= 1'b0;
    end else begin
      s_seg       <= seg;
      s_an        <= an;
      p_seg       <= s_seg;
      p_an        <= s_an;
      digit_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (!one_hot || !same) begin
        cnt  <= '0;
        done <= 1'b0;
      end else begin
        if (cnt != CNT_LAST) cnt <= cnt + CNT_ONE;
        if (commit) begin
          done        <= 1'b1;
          digit_valid <= 1'b1;
          digit_idx   <= slot;
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel[i]) begin
              digits[4*i +: 4] <= decoded[3:0];
              digit_err[i]     <= decoded[4];
            end
          end
          if (frame_full) begin
            seen       <= '0;
            frame_done <= 1'b1;
          end else begin
            seen <= seen_next;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_capture.sv
// Bench for seg_capture: a pin-level run-length model predicts commits, decoded codes and frames.
module tb_seg_capture;
  localparam int ND = 4;
  localparam int SC = 4;
  localparam int IW = 2;
  localparam logic [6:0] PAT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                      7'b0000000, 7'b0010000};
  localparam logic [6:0] DASH = 7'b0111111;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [6:0]      seg = 7'h7F;
  logic [ND-1:0]   an = '1;
  logic [4*ND-1:0] digits;
  logic [ND-1:0]   digit_err;
  logic            digit_valid;
  logic [IW-1:0]   digit_idx;
  logic            frame_done;

  seg_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC), .IDX_W(IW)) dut (
    .clk(clk), .reset(reset), .seg(seg), .an(an), .digits(digits),
    .digit_err(digit_err), .digit_valid(digit_valid), .digit_idx(digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: slot contents, frame bookkeeping and the current run of identical pin samples.
  logic [3:0]    m_dig [ND];
  logic [ND-1:0] m_err;
  logic [ND-1:0] m_seen;
  logic [6:0]    last_seg;
  logic [ND-1:0] last_an;
  int            run;
  logic [IW+4:0] exp_q [$];  // predicted commits {slot, err, code}, visible one edge later

  int step_no = 0;
  int bad_cycles, n_valid, n_frame, n_pushed, valid_step, frame_step;

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    logic [4:0] r;
    r = {1'b1, 4'hF};
    if (p == DASH) r = {1'b0, 4'hA};
    for (int d = 0; d < 10; d++) if (p == PAT[d]) r = {1'b0, 4'(d)};
    return r;
  endfunction

  function automatic int sel_slot(input logic [ND-1:0] a);
    int n = 0;
    int s = -1;
    for (int i = 0; i < ND; i++) if (a[i] == 1'b0) begin n++; s = i; end
    return (n == 1) ? s : -1;
  endfunction

  function automatic logic [4*ND-1:0] model_digits();
    logic [4*ND-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = m_dig[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
    m_err = '1;
    m_seen = '0;
    last_seg = 7'h7F;
    last_an = '1;
    run = 0;
    exp_q.delete();
  endtask

  task automatic clear_obs();
    bad_cycles = 0; n_valid = 0; n_frame = 0; n_pushed = 0;
    valid_step = -1; frame_step = -1;
  endtask

  task automatic do_reset(input logic [6:0] s, input logic [ND-1:0] a);
    seg = s; an = a; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    step_no++;
    model_reset();
  endtask

  // One clock of stimulus: applies pins, then records how the DUT output agrees with the model.
  task automatic step(input logic [6:0] s, input logic [ND-1:0] a);
    logic [IW+4:0] item;
    bit exp_v, exp_f;
    int slot;
    seg = s; an = a;
    @(posedge clk); #1;
    step_no++;
    exp_v = 0; exp_f = 0; item = '0;
    if (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      exp_v = 1;
      m_dig[item[IW+4:5]] = item[3:0];
      m_err[item[IW+4:5]] = item[4];
      m_seen[item[IW+4:5]] = 1'b1;
      if (&m_seen) begin exp_f = 1; m_seen = '0; end
    end
    if (digit_valid) begin n_valid++; valid_step = step_no; end
    if (frame_done) begin n_frame++; frame_step = step_no; end
    if (digit_valid !== exp_v || frame_done !== exp_f || (exp_v && digit_idx !== item[IW+4:5]))
      bad_cycles++;
    if (s == last_seg && a == last_an) run++; else run = 1;
    last_seg = s; last_an = a;
    slot = sel_slot(a);
    if (slot >= 0 && run == SC) begin
      exp_q.push_back({IW'(slot), ref_decode(s)});
      n_pushed++;
    end
  endtask

  task automatic hold(input logic [6:0] s, input logic [ND-1:0] a, input int n);
    for (int k = 0; k < n; k++) step(s, a);
  endtask

  task automatic test_reset();
    do_reset(7'h7F, '1);
    tests_run++; if (digits !== 16'hFFFF) begin tests_failed++; $display("FAIL reset_digits: got %h expected ffff", digits); end
    tests_run++; if (digit_err !== 4'hF) begin tests_failed++; $display("FAIL reset_err: got %b expected 1111", digit_err); end
    tests_run++; if (digit_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", digit_valid); end
    tests_run++; if (digit_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d expected 0", digit_idx); end
    tests_run++; if (frame_done !== 1'b0) begin tests_failed++; $display("FAIL reset_frame: got %b expected 0", frame_done); end
  endtask

  task automatic test_single();
    int s0;
    clear_obs();
    s0 = step_no + 1;
    hold(7'b0110000, 4'b1110, 10);
    tests_run++; if (n_valid !== 1) begin tests_failed++; $display("FAIL single_count: got %0d expected 1", n_valid); end
    tests_run++; if (valid_step !== s0 + SC) begin tests_failed++; $display("FAIL single_latency: got %0d expected %0d", valid_step - s0, SC); end
    tests_run++; if (digits[3:0] !== 4'h3) begin tests_failed++; $display("FAIL single_code: got %h expected 3", digits[3:0]); end
    tests_run++; if (digit_err[0] !== 1'b0) begin tests_failed++; $display("FAIL single_err: got %b expected 0", digit_err[0]); end
    tests_run++; if (bad_cycles !== 0) begin tests_failed++; $display("FAIL single_cycles: got %0d expected 0", bad_cycles); end
  endtask

  task automatic test_scan();
    clear_obs();
    for (int d = 0; d < ND; d++) hold(PAT[d+1], ~(ND'(1) << d), 8);
    tests_run++; if (n_valid !== 4) begin tests_failed++; $display("FAIL scan_count: got %0d expected 4", n_valid); end
    tests_run++; if (digits !== 16'h4321) begin tests_failed++; $display("FAIL scan_digits: got %h expected 4321", digits); end
    tests_run++; if (n_frame !== 1 || frame_step !== valid_step) begin tests_failed++; $display("FAIL scan_frame: got %0d at %0d expected 1 at %0d", n_frame, frame_step, valid_step); end
    tests_run++; if (bad_cycles !== 0) begin tests_failed++; $display("FAIL scan_cycles: got %0d expected 0", bad_cycles); end
  endtask

  task automatic test_glitch();
    clear_obs();
    hold(PAT[7], 4'b1101, SC - 1);
    hold(7'h7F, 4'b1111, 6);
    tests_run++; if (n_valid !== 0) begin tests_failed++; $display("FAIL glitch_count: got %0d expected 0", n_valid); end
    tests_run++; if (digits[7:4] !== 4'h2) begin tests_failed++; $display("FAIL glitch_keep: got %h expected 2", digits[7:4]); end
  endtask

  task automatic test_dash_invalid();
    clear_obs();
    hold(DASH, 4'b1011, 6);
    tests_run++; if (digits[11:8] !== 4'hA || digit_err[2] !== 1'b0) begin tests_failed++; $display("FAIL dash: got %h/%b expected a/0", digits[11:8], digit_err[2]); end
    hold(7'b1010101, 4'b1101, 6);
    tests_run++; if (digits[7:4] !== 4'hF || digit_err[1] !== 1'b1) begin tests_failed++; $display("FAIL invalid: got %h/%b expected f/1", digits[7:4], digit_err[1]); end
    tests_run++; if (n_valid !== 2 || bad_cycles !== 0) begin tests_failed++; $display("FAIL dash_count: got %0d/%0d expected 2/0", n_valid, bad_cycles); end
  endtask

  task automatic test_blank();
    logic [4*ND-1:0] snap_d;
    logic [ND-1:0] snap_e;
    logic [6:0] s;
    clear_obs();
    snap_d = digits; snap_e = digit_err;
    s = 7'($urandom);
    hold(s, 4'b0011, 10);
    hold(PAT[$urandom_range(0, 9)], 4'b1111, 10);
    tests_run++; if (n_valid !== 0 || n_frame !== 0) begin tests_failed++; $display("FAIL blank_pulses: got %0d/%0d expected 0/0", n_valid, n_frame); end
    tests_run++; if (digits !== snap_d || digit_err !== snap_e) begin tests_failed++; $display("FAIL blank_hold: got %h/%b expected %h/%b", digits, digit_err, snap_d, snap_e); end
  endtask

  task automatic test_reset_mid();
    int r;
    clear_obs();
    hold(PAT[9], 4'b0111, 2);
    do_reset(PAT[9], 4'b0111);
    r = step_no;
    tests_run++; if (digits !== 16'hFFFF || digit_err !== 4'hF || digit_valid !== 1'b0) begin tests_failed++; $display("FAIL midreset_vals: got %h/%b/%b expected ffff/1111/0", digits, digit_err, digit_valid); end
    hold(PAT[9], 4'b0111, 8);
    tests_run++; if (n_valid !== 1 || valid_step !== r + SC + 1) begin tests_failed++; $display("FAIL midreset_latency: got %0d at +%0d expected 1 at +%0d", n_valid, valid_step - r, SC + 1); end
    tests_run++; if (digits[15:12] !== 4'h9 || bad_cycles !== 0) begin tests_failed++; $display("FAIL midreset_code: got %h/%0d expected 9/0", digits[15:12], bad_cycles); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    hold(PAT[5], 4'b1110, 20);
    hold(PAT[6], 4'b1101, 6);
    tests_run++; if (n_valid !== 2) begin tests_failed++; $display("FAIL b2b_count: got %0d expected 2", n_valid); end
    tests_run++; if (digits[7:0] !== 8'h65 || bad_cycles !== 0) begin tests_failed++; $display("FAIL b2b_codes: got %h/%0d expected 65/0", digits[7:0], bad_cycles); end
  endtask

  task automatic test_random();
    logic [ND-1:0] a;
    logic [6:0] s;
    int kind;
    clear_obs();
    for (int h = 0; h < 60; h++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) a = '1;
      else if (kind == 1) a = 4'b0101;
      else a = ~(ND'(1) << $urandom_range(0, ND - 1));
      kind = $urandom_range(0, 11);
      if (kind == 10) s = 7'($urandom);
      else if (kind == 11) s = DASH;
      else s = PAT[kind];
      hold(s, a, $urandom_range(1, 8));
    end
    hold(7'h7F, '1, 3);
    tests_run++; if (bad_cycles !== 0) begin tests_failed++; $display("FAIL rand_cycles: got %0d expected 0", bad_cycles); end
    tests_run++; if (n_valid !== n_pushed) begin tests_failed++; $display("FAIL rand_count: got %0d expected %0d", n_valid, n_pushed); end
    tests_run++; if (digits !== model_digits()) begin tests_failed++; $display("FAIL rand_digits: got %h expected %h", digits, model_digits()); end
    tests_run++; if (digit_err !== m_err) begin tests_failed++; $display("FAIL rand_err: got %b expected %b", digit_err, m_err); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_scan();
    test_glitch();
    test_dash_invalid();
    test_blank();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
